// File: rtl/dice_pkg.sv
// Shared state encoding, winner codes and score arithmetic for the dice turn controller.
package dice_pkg;

    typedef enum logic [2:0] {IDLE, ROLL, LATCH, SHOW, FINAL} state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    localparam int SCORE_W = 6;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 6'd63;

    // Faces outside 1..6 are treated as a dead roll; totals clamp instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] score,
                                                   input logic [3:0]         die);
        logic [3:0]       face;
        logic [SCORE_W:0] sum;
        face = (die >= 4'd1 && die <= 4'd6) ? die : 4'd0;
        sum  = {1'b0, score} + {{(SCORE_W-3){1'b0}}, face};
        return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[SCORE_W-1:0];
    endfunction

    function automatic logic [1:0] pick_winner(input logic [SCORE_W-1:0] s1,
                                               input logic [SCORE_W-1:0] s2);
        if (s1 > s2)
            return WIN_P1;
        else if (s2 > s1)
            return WIN_P2;
        else
            return WIN_TIE;
    endfunction

endpackage

// File: rtl/tick_counter.sv
// Prescaler-tick counter shared by the roll and show windows; done marks the tick that reaches limit.
module tick_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         tick,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         done
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         at_max;

    // Saturate rather than wrap so a stalled window can never re-trigger done.
    always_comb begin
        at_max  = (count_q == {W{1'b1}});
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (en && tick && !at_max)
            count_d = count_q + W'(1);
    end

    assign done = en && tick && (count_q == limit - W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/dice_turn_ctrl.sv
// Two-player dice turn sequencer: grants roll windows, banks each frozen die into a score,
// counts rounds and registers the winner.
module dice_turn_ctrl
    import dice_pkg::*;
#(
    parameter int ROLL_TICKS = 2000,
    parameter int SHOW_TICKS = 1000,
    parameter int ROUNDS     = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               btn1,
    input  logic               btn2,
    input  logic [3:0]         dice1_in,
    input  logic [3:0]         dice2_in,
    output logic               roll1,
    output logic               roll2,
    output logic               turn,
    output logic               busy,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [3:0]         round,
    output logic               is_final,
    output logic [1:0]         winner
);

    localparam int CNT_MAX = (ROLL_TICKS > SHOW_TICKS) ? ROLL_TICKS : SHOW_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ROLL_LIMIT  = CNT_W'(ROLL_TICKS);
    localparam logic [CNT_W-1:0] SHOW_LIMIT  = CNT_W'(SHOW_TICKS);
    localparam logic [3:0]       ROUND_LIMIT = 4'(ROUNDS);

    state_t             state_q, state_d;
    logic               roll1_q, roll1_d;
    logic               roll2_q, roll2_d;
    logic               turn_q, turn_d;
    logic               busy_q, busy_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [SCORE_W-1:0] score2_q, score2_d;
    logic [3:0]         round_q, round_d;
    logic               is_final_q, is_final_d;
    logic [1:0]         winner_q, winner_d;

    logic               cnt_en;
    logic               cnt_clr;
    logic [CNT_W-1:0]   cnt_limit;
    logic               cnt_done;

    assign cnt_en    = (state_q == ROLL) || (state_q == SHOW);
    assign cnt_limit = (state_q == ROLL) ? ROLL_LIMIT : SHOW_LIMIT;
    assign cnt_clr   = (state_d != state_q);

    tick_counter #(.W(CNT_W)) u_tick_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (cnt_en),
        .tick  (tick),
        .clr   (cnt_clr),
        .limit (cnt_limit),
        .done  (cnt_done)
    );

    always_comb begin
        state_d    = state_q;
        roll1_d    = roll1_q;
        roll2_d    = roll2_q;
        turn_d     = turn_q;
        score1_d   = score1_q;
        score2_d   = score2_q;
        round_d    = round_q;
        is_final_d = is_final_q;
        winner_d   = winner_q;

        case (state_q)
            IDLE: begin
                if ((!turn_q && btn1) || (turn_q && btn2)) begin
                    state_d = ROLL;
                    roll1_d = !turn_q;
                    roll2_d = turn_q;
                end
            end
            ROLL: begin
                if (cnt_done) begin
                    state_d = LATCH;
                    roll1_d = 1'b0;
                    roll2_d = 1'b0;
                end
            end
            LATCH: begin
                if (!turn_q)
                    score1_d = sat_add(score1_q, dice1_in);
                else
                    score2_d = sat_add(score2_q, dice2_in);
                state_d = SHOW;
            end
            SHOW: begin
                if (cnt_done) begin
                    turn_d  = !turn_q;
                    round_d = turn_q ? round_q + 4'd1 : round_q;
                    if (round_d == ROUND_LIMIT) begin
                        state_d    = FINAL;
                        is_final_d = 1'b1;
                        winner_d   = pick_winner(score1_q, score2_q);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FINAL: begin
                // Only a two-handed press restarts, so a stray single press cannot wipe the result.
                if (btn1 && btn2) begin
                    state_d    = IDLE;
                    turn_d     = 1'b0;
                    score1_d   = '0;
                    score2_d   = '0;
                    round_d    = '0;
                    is_final_d = 1'b0;
                    winner_d   = WIN_NONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            roll1_q    <= 1'b0;
            roll2_q    <= 1'b0;
            turn_q     <= 1'b0;
            busy_q     <= 1'b0;
            score1_q   <= '0;
            score2_q   <= '0;
            round_q    <= '0;
            is_final_q <= 1'b0;
            winner_q   <= WIN_NONE;
        end else begin
            state_q    <= state_d;
            roll1_q    <= roll1_d;
            roll2_q    <= roll2_d;
            turn_q     <= turn_d;
            busy_q     <= busy_d;
            score1_q   <= score1_d;
            score2_q   <= score2_d;
            round_q    <= round_d;
            is_final_q <= is_final_d;
            winner_q   <= winner_d;
        end
    end

    assign roll1    = roll1_q;
    assign roll2    = roll2_q;
    assign turn     = turn_q;
    assign busy     = busy_q;
    assign score1   = score1_q;
    assign score2   = score2_q;
    assign round    = round_q;
    assign is_final = is_final_q;
    assign winner   = winner_q;

endmodule

// File: tb/tb_dice_turn_ctrl.sv
// Randomised self-checking bench for dice_turn_ctrl: a short game instance (2 rounds) and a
// long game instance (10 rounds), both judged against a game-level model of scores and turns.
module tb_dice_turn_ctrl;
    import dice_pkg::*;

    localparam int RT       = 3;
    localparam int ST       = 2;
    localparam int ROUNDS_A = 2;
    localparam int ROUNDS_B = 10;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       tick = 1'b0;
    logic       btn1_i   [2];
    logic       btn2_i   [2];
    logic [3:0] dice1_i  [2];
    logic [3:0] dice2_i  [2];
    logic       roll1_o  [2];
    logic       roll2_o  [2];
    logic       turn_o   [2];
    logic       busy_o   [2];
    logic [5:0] score1_o [2];
    logic [5:0] score2_o [2];
    logic [3:0] round_o  [2];
    logic       final_o  [2];
    logic [1:0] winner_o [2];

    int num_checks = 0;
    int num_fails  = 0;
    int idle_run   = 0;

    int m_score1 [2];
    int m_score2 [2];
    int m_round  [2];
    int m_turn   [2];
    int m_final  [2];
    int m_winner [2];
    int rounds_of[2];

    always #5 clk = ~clk;

    dice_turn_ctrl #(.ROLL_TICKS(RT), .SHOW_TICKS(ST), .ROUNDS(ROUNDS_A)) u_dut_a (
        .clk(clk), .rst(rst), .tick(tick),
        .btn1(btn1_i[0]), .btn2(btn2_i[0]),
        .dice1_in(dice1_i[0]), .dice2_in(dice2_i[0]),
        .roll1(roll1_o[0]), .roll2(roll2_o[0]), .turn(turn_o[0]), .busy(busy_o[0]),
        .score1(score1_o[0]), .score2(score2_o[0]), .round(round_o[0]),
        .is_final(final_o[0]), .winner(winner_o[0])
    );

    dice_turn_ctrl #(.ROLL_TICKS(RT), .SHOW_TICKS(ST), .ROUNDS(ROUNDS_B)) u_dut_b (
        .clk(clk), .rst(rst), .tick(tick),
        .btn1(btn1_i[1]), .btn2(btn2_i[1]),
        .dice1_in(dice1_i[1]), .dice2_in(dice2_i[1]),
        .roll1(roll1_o[1]), .roll2(roll2_o[1]), .turn(turn_o[1]), .busy(busy_o[1]),
        .score1(score1_o[1]), .score2(score2_o[1]), .round(round_o[1]),
        .is_final(final_o[1]), .winner(winner_o[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", tag, actual, expected, $time);
        end
    endtask

    // Random tick stream, but never more than six quiet cycles in a row so every window ends.
    function automatic logic randTick();
        logic t;
        t = ($urandom_range(0, 2) == 0) || (idle_run >= 6);
        idle_run = t ? 0 : idle_run + 1;
        return t;
    endfunction

    function automatic int faceOf(input int die);
        return (die >= 1 && die <= 6) ? die : 0;
    endfunction

    function automatic int randDie();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 6));
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            m_score1[i] = 0;
            m_score2[i] = 0;
            m_round[i]  = 0;
            m_turn[i]   = 0;
            m_final[i]  = 0;
            m_winner[i] = 0;
        end
    endtask

    // One clock of stimulus: inputs driven just after a falling edge, held through the rising edge.
    task automatic applyStimulus(input int d, input logic t, input logic b1, input logic b2);
        tick      = t;
        btn1_i[d] = b1;
        btn2_i[d] = b2;
        @(posedge clk);
        @(negedge clk);
        tick      = 1'b0;
        btn1_i[d] = 1'b0;
        btn2_i[d] = 1'b0;
    endtask

    task automatic checkGame(input int d);
        checkOutput("score1", score1_o[d], m_score1[d]);
        checkOutput("score2", score2_o[d], m_score2[d]);
        checkOutput("round", round_o[d], m_round[d]);
        checkOutput("turn", turn_o[d], m_turn[d]);
        checkOutput("is_final", final_o[d], m_final[d]);
        checkOutput("winner", winner_o[d], m_winner[d]);
    endtask

    task automatic playTurn(input int d, input int die, input bit both_press, input bit noise);
        int   p;
        int   ticks;
        logic t;
        p = m_turn[d];

        checkOutput("busy_idle", busy_o[d], 0);
        checkOutput("roll_idle", {roll1_o[d], roll2_o[d]}, 0);
        applyStimulus(d, randTick(), (p == 1) && noise, (p == 0) && noise);
        checkOutput("busy_wrong_btn", busy_o[d], 0);
        checkOutput("turn_wrong_btn", turn_o[d], p);

        applyStimulus(d, randTick(), (p == 0) || both_press, (p == 1) || both_press);
        ticks = 0;
        while (ticks < RT) begin
            checkOutput("roll1_window", roll1_o[d], p == 0);
            checkOutput("roll2_window", roll2_o[d], p == 1);
            checkOutput("busy_roll", busy_o[d], 1);
            dice1_i[d] = 4'($urandom_range(0, 15));
            dice2_i[d] = 4'($urandom_range(0, 15));
            t = randTick();
            if (t) ticks++;
            applyStimulus(d, t, noise && ($urandom_range(0, 3) == 0), noise && ($urandom_range(0, 3) == 0));
        end

        checkOutput("roll_off_latch", {roll1_o[d], roll2_o[d]}, 0);
        checkOutput("busy_latch", busy_o[d], 1);
        if (p == 0) begin
            dice1_i[d] = 4'(die);
            dice2_i[d] = 4'($urandom_range(0, 15));
        end else begin
            dice2_i[d] = 4'(die);
            dice1_i[d] = 4'($urandom_range(0, 15));
        end
        applyStimulus(d, randTick(), noise && ($urandom_range(0, 1) == 0), noise && ($urandom_range(0, 1) == 0));
        if (p == 0)
            m_score1[d] = (m_score1[d] + faceOf(die) > 63) ? 63 : m_score1[d] + faceOf(die);
        else
            m_score2[d] = (m_score2[d] + faceOf(die) > 63) ? 63 : m_score2[d] + faceOf(die);
        checkOutput("score1_after_latch", score1_o[d], m_score1[d]);
        checkOutput("score2_after_latch", score2_o[d], m_score2[d]);

        ticks = 0;
        while (ticks < ST) begin
            checkOutput("turn_show", turn_o[d], p);
            checkOutput("round_show", round_o[d], m_round[d]);
            checkOutput("busy_show", busy_o[d], 1);
            checkOutput("roll_show", {roll1_o[d], roll2_o[d]}, 0);
            t = randTick();
            if (t) ticks++;
            applyStimulus(d, t, noise && ($urandom_range(0, 2) == 0), noise && ($urandom_range(0, 2) == 0));
        end

        m_turn[d] = 1 - p;
        if (p == 1) m_round[d]++;
        if (m_round[d] == rounds_of[d]) begin
            m_final[d]  = 1;
            m_winner[d] = (m_score1[d] > m_score2[d]) ? 1 : (m_score2[d] > m_score1[d]) ? 2 : 3;
        end
        checkGame(d);
        checkOutput("busy_after_show", busy_o[d], m_final[d]);
    endtask

    task automatic finalChecks(input int d);
        applyStimulus(d, randTick(), 1'b1, 1'b0);
        checkGame(d);
        checkOutput("busy_final_btn1", busy_o[d], 1);
        applyStimulus(d, randTick(), 1'b0, 1'b1);
        checkGame(d);
        applyStimulus(d, randTick(), 1'b1, 1'b1);
        m_score1[d] = 0;
        m_score2[d] = 0;
        m_round[d]  = 0;
        m_turn[d]   = 0;
        m_final[d]  = 0;
        m_winner[d] = 0;
        checkGame(d);
        checkOutput("busy_new_game", busy_o[d], 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            btn1_i[i]  = 1'b0;
            btn2_i[i]  = 1'b0;
            dice1_i[i] = 4'd0;
            dice2_i[i] = 4'd0;
        end
        rounds_of[0] = ROUNDS_A;
        rounds_of[1] = ROUNDS_B;
        modelReset();

        repeat (4) applyStimulus(0, randTick(), 1'b0, 1'b0);
        checkGame(0);
        checkGame(1);
        checkOutput("busy_reset", busy_o[0], 0);
        checkOutput("roll_reset", {roll1_o[0], roll2_o[0], roll1_o[1], roll2_o[1]}, 0);
        #2 rst = 1'b1;

        applyStimulus(0, randTick(), 1'b0, 1'b1);
        checkOutput("roll2_wrong_player", roll2_o[0], 0);
        checkOutput("busy_wrong_player", busy_o[0], 0);
        checkOutput("turn_wrong_player", turn_o[0], 0);

        playTurn(0, 6, 1'b0, 1'b0);
        playTurn(0, 3, 1'b1, 1'b1);
        playTurn(0, 2, 1'b0, 1'b1);
        playTurn(0, 4, 1'b0, 1'b0);
        checkOutput("game_a_score1", score1_o[0], 8);
        checkOutput("game_a_score2", score2_o[0], 7);
        checkOutput("game_a_winner", winner_o[0], 1);
        checkOutput("game_a_round", round_o[0], 2);
        finalChecks(0);

        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < 2 * ROUNDS_A; k++)
                playTurn(0, (g == 0 && k == 0) ? 7 : randDie(), 1'($urandom_range(0, 1)), 1'b1);
            finalChecks(0);
        end

        applyStimulus(0, 1'b0, 1'b1, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        checkOutput("roll1_before_reset", roll1_o[0], 1);
        #1 rst = 1'b0;
        #1;
        checkOutput("roll1_async_reset", roll1_o[0], 0);
        checkOutput("busy_async_reset", busy_o[0], 0);
        modelReset();
        @(negedge clk);
        checkGame(0);
        #2 rst = 1'b1;
        playTurn(0, 5, 1'b0, 1'b0);
        checkOutput("score1_after_reset_turn", score1_o[0], 5);

        for (int k = 0; k < 2 * ROUNDS_B; k++)
            playTurn(1, 6, 1'b0, 1'b0);
        checkOutput("game_b_score1", score1_o[1], 60);
        checkOutput("game_b_score2", score2_o[1], 60);
        checkOutput("game_b_winner", winner_o[1], 3);
        checkOutput("game_b_round", round_o[1], 10);
        finalChecks(1);

        checkOutput("sat_61_plus_6", sat_add(6'd61, 4'd6), 63);
        checkOutput("face_7_adds_0", sat_add(6'd10, 4'd7), 10);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule

// File: doc/dice_turn_ctrl.md
# dice_turn_ctrl

Turn sequencer and arbiter for the two-player dice game. It decides which player may roll and drives the roller's per-die enables for a fixed tick-timed window. After each window it latches the frozen die value and accumulates it into that player's score. It counts rounds and declares the winner. It sits between the debouncers/prescaler and the roller, score display and end-of-game effects, and replaces ad-hoc button-to-roller wiring.

## Interface
Parameters:
- ROLL_TICKS, 2000: tick pulses a roll window lasts (≥1).
- SHOW_TICKS, 1000: tick pulses the result is held before the turn passes (≥1).
- ROUNDS, 5: rounds per game; each round is one turn per player (1..10).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle enable from the prescaler; all durations count ticks.
- btn1, btn2  in  1  debounced one-cycle press pulses, player 1 / player 2.
- dice1_in, dice2_in  in  4  current roller values; legal range 1..6.
- roll1, roll2  out  1  roller enable for die 1 / die 2; at most one is high.
- turn  out  1  0 = player 1 to act, 1 = player 2.
- busy  out  1  high outside IDLE; drives the debouncer lockout.
- score1, score2  out  6  accumulated scores.
- round  out  4  completed rounds, 0..ROUNDS.
- is_final  out  1  game over.
- winner  out  2  00 none, 01 player 1, 10 player 2, 11 tie.

## Operation
- States: IDLE, ROLL, LATCH, SHOW, FINAL.
- IDLE:
  - A pulse on the button matching turn moves the block to ROLL.
  - The other player's button is ignored.
  - If btn1 and btn2 arrive in the same cycle, only the button matching turn counts.
- ROLL:
  - roll1 is high when turn=0; roll2 is high when turn=1.
  - Tick counter runs from 0.
  - On the tick that brings the count to ROLL_TICKS, go to LATCH. The roll enable drops with that transition.
- LATCH (exactly one cycle):
  - Sample the die for the current turn.
  - Add the value to that player's score, saturating at 63.
  - Values 0 or 7..15 add 0.
  - Go to SHOW.
- SHOW:
  - Count SHOW_TICKS ticks, then toggle turn.
  - When turn was 1, also increment round.
  - If the new round equals ROUNDS, go to FINAL; otherwise go to IDLE.
- FINAL:
  - is_final=1 and winner is registered from the score comparison.
  - Buttons are ignored unless btn1 and btn2 arrive in the same cycle. That clears scores, round, turn, winner and is_final, and returns to IDLE (new game).
- Buttons outside IDLE and FINAL are ignored and are not queued.

## Timing
- Reset (asynchronous, any state, including mid-roll):
  - State returns to IDLE.
  - All outputs 0: roll1=roll2=0, turn=0, busy=0, scores 0, round 0, is_final 0, winner 00.
  - Tick counter is cleared.
- Button pulse in IDLE at cycle N: state=ROLL and roll enable high at N+1.
- Roll window: from the first cycle of ROLL to the cycle after the ROLL_TICKS-th tick. A tick in the entry cycle counts.
- Die sampling happens in the LATCH cycle, one cycle after the roll enable falls, so the roller is already frozen.
- Score is visible the cycle after LATCH.
- turn, round and is_final all update on the same edge as the SHOW exit.
- winner is valid on the same edge as is_final rises.
- busy is a registered copy of (state≠IDLE), so it has no combinational path from the buttons.
- Tick counter is shared by ROLL and SHOW. It clears on every state entry and does not wrap.

## Structure
- Package dice_pkg holds:
  - state enum (IDLE, ROLL, LATCH, SHOW, FINAL);
  - winner encodings (WIN_NONE, WIN_P1, WIN_P2, WIN_TIE);
  - SCORE_W=6 and SCORE_MAX=63.
- One sub-module, tick_counter: count enable, synchronous clear, done flag when count reaches a programmable limit. It is instantiated once, with its limit muxed between ROLL_TICKS and SHOW_TICKS.
- The FSM, score accumulators and winner compare live in dice_turn_ctrl.

## Test plan
- Reset with tick free-running:
  - All outputs 0 and state IDLE.
  - btn2 pulse → no roll2, turn stays 0.
- ROLL_TICKS=3, SHOW_TICKS=2:
  - btn1 pulse → roll1 high for exactly 3 ticks, roll2 stays 0.
  - dice1_in=5 → score1=5 the cycle after LATCH.
  - After 2 ticks → turn=1, round=0.
- btn1 and btn2 pulsed in the same cycle while turn=1 → only player 2 rolls.
  - A btn2 pulse during ROLL is ignored: no second roll after SHOW.
- Full game, ROUNDS=2:
  - Player 1 rolls 6, 2; player 2 rolls 3, 4.
  - Result: round=2, is_final=1, winner=01, score1=8, score2=7.
  - A single btn1 pulse changes nothing; a simultaneous btn1+btn2 pulse clears everything to 0 and returns to IDLE.
- rst asserted low mid-ROLL with roll1=1 → roll1 drops with no clock edge; after release, a new btn1 press starts a complete ROLL_TICKS window.
- dice1_in=7 in LATCH adds 0. With ROUNDS=10 and all rolls 6, scores reach 60 with no overflow; a score forced to 61 plus 6 saturates at 63.
